z88_blink_mmu: RTL and testbench

Parametrised Blink memory-management unit between the tv80s core and the ROM/RAM/card buses of the z88 top level. It provides IO-writable segment registers SR0..SR3 and COM, translates 16-bit CPU addresses into physical bank addresses, and decodes ROM/RAM/card chip-selects. It also generates per-region wait states through a small FSM, so slow ROM or card memory can sit on the same bus as fast internal RAM.

---
 rtl/z88_blink_mmu.sv | 178 +++++++++++++++++
 tb/tb_z88_blink_mmu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z88_blink_mmu.sv
// Blink MMU: segment/COM registers, CPU-to-physical bank translation, region decode
// and per-region memory wait-state generation for the z88 tv80s bus.
module z88_blink_mmu #(
   parameter int                BANK_W      = 8,
   parameter logic [BANK_W-1:0] RAM_BANK_LO = 8'h20,
   parameter logic [BANK_W-1:0] EXT_BANK_LO = 8'h40,
   parameter logic [BANK_W-1:0] RAMS_BANK   = 8'h20,
   parameter int                ROM_WAIT    = 1,
   parameter int                RAM_WAIT    = 0,
   parameter int                EXT_WAIT    = 2,
   parameter logic [7:0]        SR_BASE     = 8'hD0,
   parameter logic [7:0]        COM_BASE    = 8'hB0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [15:0]          cpu_a,
   input  logic [7:0]           cpu_do,
   input  logic                 cpu_mreq_n,
   input  logic                 cpu_iorq_n,
   input  logic                 cpu_rd_n,
   input  logic                 cpu_wr_n,
   input  logic                 cpu_m1_n,
   input  logic                 cpu_rfsh_n,
   output logic                 cpu_wait_n,
   output logic [7:0]           io_do,
   output logic                 io_oe,
   output logic [BANK_W+13:0]   pa,
   output logic                 rom_sel,
   output logic                 ram_sel,
   output logic                 ext_sel,
   output logic [7:0]           com_out
);

   if (ROM_WAIT < 0 || ROM_WAIT > 15 || RAM_WAIT < 0 || RAM_WAIT > 15 ||
       EXT_WAIT < 0 || EXT_WAIT > 15) begin : g_wait_range_bad
      $error("z88_blink_mmu: wait counts must be in 0..15");
   end

   localparam logic [3:0] ROM_N = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_N = 4'(RAM_WAIT);
   localparam logic [3:0] EXT_N = 4'(EXT_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   logic [BANK_W-1:0] sr_reg [4];
   logic [7:0]        com_reg;
   state_t            state_reg;
   logic [3:0]        cnt_reg;
   logic              mreq_n_prev_reg;
   logic              io_wr_idle_prev_reg;

   logic [3:0]        sr_hit;
   logic              com_hit;
   logic              io_wr;
   logic              io_wr_edge;
   logic              io_rd;
   logic [BANK_W-1:0] bank;
   logic [3:0]        n_sel;
   logic              start;

   // ---------------- IO address decode ----------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sr_hit
         assign sr_hit[gi] = (cpu_a[7:0] == 8'(SR_BASE + gi));
      end
   endgenerate

   assign com_hit    = (cpu_a[7:0] == COM_BASE);
   assign io_wr      = !cpu_iorq_n && !cpu_wr_n && cpu_m1_n;
   assign io_rd      = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n;
   assign io_wr_edge = io_wr && io_wr_idle_prev_reg;

   always_comb begin
      io_do = 8'h00;
      io_oe = 1'b0;
      if (io_rd) begin
         if (com_hit) begin
            io_do = com_reg;
            io_oe = 1'b1;
         end
         for (int i = 0; i < 4; i++) begin
            if (sr_hit[i]) begin
               io_do = 8'(sr_reg[i]);
               io_oe = 1'b1;
            end
         end
      end
   end

   // ---------------- Address translation and region decode ----------------
   always_comb begin
      bank = '0;
      if (cpu_a[15:14] == 2'd0) begin
         // Bottom 8K is either the fixed ROM bank 0 or the RAMS bank, chosen by COM[2].
         if (cpu_a[13])
            bank = sr_reg[0];
         else
            bank = com_reg[2] ? RAMS_BANK : '0;
      end else begin
         bank = sr_reg[cpu_a[15:14]];
      end
   end

   assign pa      = {bank, cpu_a[13:0]};
   assign rom_sel = (bank < RAM_BANK_LO);
   assign ram_sel = (bank >= RAM_BANK_LO) && (bank < EXT_BANK_LO);
   assign ext_sel = !rom_sel && !ram_sel;
   assign com_out = com_reg;

   // ---------------- Wait-state generation ----------------
   always_comb begin
      if (rom_sel)
         n_sel = ROM_N;
      else if (ram_sel)
         n_sel = RAM_N;
      else
         n_sel = EXT_N;
   end

   assign start = (state_reg == ST_IDLE) && !cpu_mreq_n && mreq_n_prev_reg &&
                  cpu_rfsh_n && cpu_iorq_n;

   // The first wait cycle is the start cycle itself, so the counter holds N-1.
   assign cpu_wait_n = !((start && (n_sel != 4'd0)) || (state_reg == ST_WAIT));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) sr_reg[i] <= '0;
         com_reg             <= 8'h00;
         state_reg           <= ST_IDLE;
         cnt_reg             <= 4'd0;
         mreq_n_prev_reg     <= 1'b1;
         io_wr_idle_prev_reg <= 1'b1;
      end else begin
         mreq_n_prev_reg     <= cpu_mreq_n;
         io_wr_idle_prev_reg <= !io_wr;

         if (io_wr_edge) begin
            for (int i = 0; i < 4; i++) begin
               if (sr_hit[i]) sr_reg[i] <= BANK_W'(cpu_do);
            end
            if (com_hit) com_reg <= cpu_do;
         end

         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (n_sel > 4'd1) begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= n_sel - 4'd1;
                  end else begin
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_WAIT: begin
               if (cpu_mreq_n) begin
                  state_reg <= ST_IDLE;
                  cnt_reg   <= 4'd0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
                  if (cnt_reg == 4'd1) state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (cpu_mreq_n) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z88_blink_mmu.sv
// Directed bench for z88_blink_mmu: translation, region decode, IO registers and wait states.
module tb_z88_blink_mmu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_do;
   logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;
   logic        cpu_wait_n;
   logic [7:0]  io_do;
   logic        io_oe;
   logic [21:0] pa;
   logic        rom_sel, ram_sel, ext_sel;
   logic [7:0]  com_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] rd_data;
   logic       rd_oe;
   logic [7:0] pat;

   z88_blink_mmu #(
      .ROM_WAIT(2),
      .RAM_WAIT(0),
      .EXT_WAIT(3)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cpu_a(cpu_a),
      .cpu_do(cpu_do),
      .cpu_mreq_n(cpu_mreq_n),
      .cpu_iorq_n(cpu_iorq_n),
      .cpu_rd_n(cpu_rd_n),
      .cpu_wr_n(cpu_wr_n),
      .cpu_m1_n(cpu_m1_n),
      .cpu_rfsh_n(cpu_rfsh_n),
      .cpu_wait_n(cpu_wait_n),
      .io_do(io_do),
      .io_oe(io_oe),
      .pa(pa),
      .rom_sel(rom_sel),
      .ram_sel(ram_sel),
      .ext_sel(ext_sel),
      .com_out(com_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      cpu_a = {8'h00, addr};
      cpu_do = data;
      cpu_iorq_n = 1'b0;
      cpu_wr_n = 1'b0;
      @(negedge clk);
      cpu_iorq_n = 1'b1;
      cpu_wr_n = 1'b1;
   endtask

   task automatic io_read(input logic [7:0] addr, input logic m1, output logic [7:0] data,
                          output logic oe);
      @(negedge clk);
      cpu_a = {8'h00, addr};
      cpu_m1_n = m1;
      cpu_iorq_n = 1'b0;
      cpu_rd_n = 1'b0;
      #1;
      data = io_do;
      oe = io_oe;
      @(negedge clk);
      cpu_iorq_n = 1'b1;
      cpu_rd_n = 1'b1;
      cpu_m1_n = 1'b1;
   endtask

   // Holds mreq low 8 cycles; bit i of pat is cpu_wait_n in cycle i of the access.
   task automatic mem_access(input logic [15:0] addr, input logic rfsh, output logic [7:0] p);
      @(negedge clk);
      cpu_a = addr;
      cpu_mreq_n = 1'b0;
      cpu_rd_n = rfsh;
      cpu_rfsh_n = !rfsh;
      for (int i = 0; i < 8; i++) begin
         #1 p[i] = cpu_wait_n;
         @(negedge clk);
      end
      cpu_mreq_n = 1'b1;
      cpu_rd_n = 1'b1;
      cpu_rfsh_n = 1'b1;
   endtask

   task automatic set_addr(input logic [15:0] addr);
      @(negedge clk);
      cpu_a = addr;
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      cpu_a = 16'h0000;
      cpu_do = 8'h00;
      cpu_mreq_n = 1'b1;
      cpu_iorq_n = 1'b1;
      cpu_rd_n = 1'b1;
      cpu_wr_n = 1'b1;
      cpu_m1_n = 1'b1;
      cpu_rfsh_n = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      set_addr(16'h2000);
      check("rst_pa", 32'(pa), 32'h002000);
      check("rst_rom_sel", 32'(rom_sel), 32'd1);
      check("rst_wait_n", 32'(cpu_wait_n), 32'd1);
      check("rst_com", 32'(com_out), 32'h00);

      // Segment registers
      io_write(8'hD2, 8'h21);
      set_addr(16'h8123);
      check("sr2_pa", 32'(pa), 32'h084123);
      check("sr2_ram_sel", 32'({rom_sel, ram_sel, ext_sel}), 32'b010);
      io_write(8'hD3, 8'h45);
      set_addr(16'hC000);
      check("sr3_pa", 32'(pa), 32'h114000);
      check("sr3_ext_sel", 32'({rom_sel, ram_sel, ext_sel}), 32'b001);

      // COM[2] selects the RAMS bank in the bottom 8K
      io_write(8'hB0, 8'h04);
      check("com_out_04", 32'(com_out), 32'h04);
      set_addr(16'h0100);
      check("rams_pa", 32'(pa), 32'h080100);
      check("rams_ram_sel", 32'({rom_sel, ram_sel, ext_sel}), 32'b010);
      set_addr(16'h2100);
      check("sr0_hi_pa", 32'(pa), 32'h002100);
      io_write(8'hB0, 8'h00);
      set_addr(16'h0100);
      check("rom0_pa", 32'(pa), 32'h000100);
      check("rom0_rom_sel", 32'({rom_sel, ram_sel, ext_sel}), 32'b100);

      // IO read-back
      io_write(8'hD1, 8'h5A);
      io_read(8'hD1, 1'b1, rd_data, rd_oe);
      check("in_d1_oe", 32'(rd_oe), 32'd1);
      check("in_d1_data", 32'(rd_data), 32'h5A);
      io_read(8'hD1, 1'b0, rd_data, rd_oe);
      check("inta_oe", 32'(rd_oe), 32'd0);
      check("inta_data", 32'(rd_data), 32'h00);
      io_read(8'h55, 1'b1, rd_data, rd_oe);
      check("in_miss_oe", 32'(rd_oe), 32'd0);
      set_addr(16'h4000);
      check("sr1_pa", 32'(pa), 32'h168000);

      // Write strobe held for 3 cycles with changing data
      @(negedge clk);
      cpu_a = 16'h00D0;
      cpu_do = 8'h11;
      cpu_iorq_n = 1'b0;
      cpu_wr_n = 1'b0;
      @(negedge clk);
      cpu_do = 8'h22;
      @(negedge clk);
      cpu_do = 8'h33;
      @(negedge clk);
      cpu_iorq_n = 1'b1;
      cpu_wr_n = 1'b1;
      io_read(8'hD0, 1'b1, rd_data, rd_oe);
      check("held_wr_sr0", 32'(rd_data), 32'h11);
      set_addr(16'h2000);
      check("held_wr_pa", 32'(pa), 32'h046000);

      // Non-matching IO write changes nothing
      io_write(8'h55, 8'hFF);
      io_read(8'hD0, 1'b1, rd_data, rd_oe);
      check("miss_wr_sr0", 32'(rd_data), 32'h11);
      io_read(8'hB0, 1'b1, rd_data, rd_oe);
      check("miss_wr_com", 32'(rd_data), 32'h00);

      // Wait states: ROM=2, RAM=0, card=3, refresh none
      mem_access(16'h2000, 1'b0, pat);
      check("rom_wait_pat", 32'(pat), 32'hFC);
      mem_access(16'h8123, 1'b0, pat);
      check("ram_wait_pat", 32'(pat), 32'hFF);
      mem_access(16'hC000, 1'b0, pat);
      check("ext_wait_pat", 32'(pat), 32'hF8);
      mem_access(16'h2000, 1'b1, pat);
      check("rfsh_wait_pat", 32'(pat), 32'hFF);
      mem_access(16'h2000, 1'b0, pat);
      check("rom_rearm_pat", 32'(pat), 32'hFC);

      // Abort: mreq released during WAIT
      @(negedge clk);
      cpu_a = 16'hC000;
      cpu_mreq_n = 1'b0;
      cpu_rd_n = 1'b0;
      #1 check("abort_first_wait", 32'(cpu_wait_n), 32'd0);
      @(negedge clk);
      cpu_mreq_n = 1'b1;
      cpu_rd_n = 1'b1;
      @(negedge clk);
      #1 check("abort_idle_wait_n", 32'(cpu_wait_n), 32'd1);
      mem_access(16'hC000, 1'b0, pat);
      check("after_abort_pat", 32'(pat), 32'hF8);

      // Reset asserted on the second card wait cycle
      @(negedge clk);
      cpu_a = 16'hC000;
      cpu_mreq_n = 1'b0;
      cpu_rd_n = 1'b0;
      @(negedge clk);
      #1 check("pre_rst_wait", 32'(cpu_wait_n), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      cpu_mreq_n = 1'b1;
      cpu_rd_n = 1'b1;
      #1 check("mid_rst_wait_n", 32'(cpu_wait_n), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      check("mid_rst_com", 32'(com_out), 32'h00);
      io_read(8'hD0, 1'b1, rd_data, rd_oe);
      check("mid_rst_sr0", 32'(rd_data), 32'h00);
      io_read(8'hD1, 1'b1, rd_data, rd_oe);
      check("mid_rst_sr1", 32'(rd_data), 32'h00);
      io_read(8'hD2, 1'b1, rd_data, rd_oe);
      check("mid_rst_sr2", 32'(rd_data), 32'h00);
      io_read(8'hD3, 1'b1, rd_data, rd_oe);
      check("mid_rst_sr3", 32'(rd_data), 32'h00);
      set_addr(16'hC000);
      check("mid_rst_pa", 32'(pa), 32'h000000);
      io_write(8'hD3, 8'h45);
      mem_access(16'hC000, 1'b0, pat);
      check("fresh_ext_pat", 32'(pat), 32'hF8);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
